// File: rtl/csa_resolve_pipe.sv
// -----------------------------------------------------------------------------
// csa_resolve_pipe
//
// Purpose:
//   This is the final carry-propagate stage after the CSA compression tree in
//   the squaring circuit. It takes the redundant sum/carry pair and resolves it
//   into one binary result. The adder is split into two pipeline stages: the low
//   LO_W bits are added in stage 1 and the high IN_W-LO_W bits in stage 2. Both
//   sides of the block use valid/ready handshakes. The squared membrane-potential
//   term produced here feeds the Izhikevich update datapath.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   sum/carry pair presented
//   in_ready   stage 1 can accept (no combinational path from in_valid)
//   in_sum     sum vector (XOR outputs of the tree)
//   in_carry   carry vector, unshifted: bit i has weight 2^(i+1)
//   out_valid  result available
//   out_ready  consumer accepts result
//   out_result (in_sum + (in_carry << 1)) mod 2^IN_W, registered
//   out_ovf    exact sum was >= 2^IN_W, registered
// -----------------------------------------------------------------------------
module csa_resolve_pipe #(
  parameter int IN_W = 40,
  parameter int LO_W = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_sum,
  input  logic [IN_W-1:0] in_carry,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IN_W-1:0] out_result,
  output logic            out_ovf
);

  localparam int HI_W = IN_W - LO_W;

  // Operand formation. The carry vector is shifted left by one to line it up
  // with its true weight. The bit shifted out of the top is not part of the
  // IN_W-bit sum, so it is tracked separately and only contributes to out_ovf.
  logic [IN_W-1:0] op_a;
  logic [IN_W-1:0] op_b;
  logic            top_c;

  assign op_a  = in_sum;
  assign op_b  = {in_carry[IN_W-2:0], 1'b0};
  assign top_c = in_carry[IN_W-1];

  // Low-half addition. The extra MSB of the sum is the carry into stage 2.
  logic [LO_W:0] lo_sum;
  assign lo_sum = {1'b0, op_a[LO_W-1:0]} + {1'b0, op_b[LO_W-1:0]};

  // Stage 1 state
  logic            s1_valid;
  logic [LO_W-1:0] s1_lo_res;
  logic            s1_c_lo;
  logic [HI_W-1:0] s1_a_hi;
  logic [HI_W-1:0] s1_b_hi;
  logic            s1_top_c;

  // Handshake control. in_ready depends only on registered state and on
  // out_ready, so no combinational loop can form through an upstream
  // producer that waits on in_ready before raising in_valid.
  logic s2_adv;
  logic accept;

  assign s2_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;

  // High-half addition. It uses the stage-1 registers and the low-half carry.
  logic [HI_W:0] hi_sum;
  assign hi_sum = {1'b0, s1_a_hi} + {1'b0, s1_b_hi} + {{HI_W{1'b0}}, s1_c_lo};

  // Stage 1: capture the low-half result and pass the high operands through.
  // When there is no new accept but stage 2 takes the contents, stage 1 empties.
  // NOTE: Sequential state uses non-blocking (<=) assignments only. Every
  // register then samples pre-edge values, so the s1 -> s2 hand-off and the
  // new capture into s1 can happen on the same edge without ordering hazards.
  // NOTE: The datapath registers are reset together with the valid bits,
  // because out_result must read 0 while in reset. They are plain flops, not
  // a memory array, so resetting them is cheap and legal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_lo_res <= '0;
      s1_c_lo   <= 1'b0;
      s1_a_hi   <= '0;
      s1_b_hi   <= '0;
      s1_top_c  <= 1'b0;
    end else if (accept) begin
      s1_valid  <= 1'b1;
      s1_lo_res <= lo_sum[LO_W-1:0];
      s1_c_lo   <= lo_sum[LO_W];
      s1_a_hi   <= op_a[IN_W-1:LO_W];
      s1_b_hi   <= op_b[IN_W-1:LO_W];
      s1_top_c  <= top_c;
    end else if (s2_adv) begin
      s1_valid  <= 1'b0;
    end
  end

  // Stage 2: finish the high half and present the result. While out_valid is
  // high and out_ready is low, s2_adv is low, so the result stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_ovf    <= 1'b0;
    end else if (s2_adv) begin
      out_valid  <= 1'b1;
      out_result <= {hi_sum[HI_W-1:0], s1_lo_res};
      out_ovf    <= hi_sum[HI_W] | s1_top_c;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_csa_resolve_pipe.sv
// -----------------------------------------------------------------------------
// tb_csa_resolve_pipe
//
// Self-checking bench for csa_resolve_pipe (IN_W=40, LO_W=20).
// A negedge monitor keeps a scoreboard. It pushes the model result for each
// accepted input and pops and compares on each output transfer. The directed
// steps in the main initial block also check latency, stall stability,
// in_ready behaviour and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_csa_resolve_pipe;

  localparam int IN_W = 40;
  localparam int LO_W = 20;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] in_sum;
  logic [IN_W-1:0] in_carry;
  logic            out_valid;
  logic            out_ready;
  logic [IN_W-1:0] out_result;
  logic            out_ovf;

  csa_resolve_pipe #(.IN_W(IN_W), .LO_W(LO_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  logic [IN_W:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the exact sum is computed at full width, and the overflow flag
  // is set when anything lands at or above bit IN_W.
  function automatic logic [IN_W:0] model(input logic [IN_W-1:0] s, input logic [IN_W-1:0] c);
    logic [IN_W+1:0] exact;
    exact = {2'b00, s} + {1'b0, c, 1'b0};
    return {|exact[IN_W+1:IN_W], exact[IN_W-1:0]};
  endfunction

  // Scoreboard monitor. Inputs are stable between posedge+1 and the next
  // posedge, so the handshakes seen here are the ones that fire at that posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) sb_q.push_back(model(in_sum, in_carry));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          check("sb_result", 64'({out_ovf, out_result}), 64'(sb_q.pop_front()));
          n_out++;
        end
      end
    end
  end

  // Single transaction on an empty pipe with out_ready high. It checks the
  // two-stage latency and the result on the exact edge it should appear.
  task automatic apply(input string tag, input logic [IN_W-1:0] s, input logic [IN_W-1:0] c);
    logic [IN_W:0] exp;
    exp = model(s, c);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sum    = s;
    in_carry  = c;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_valid_edge0"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, "_valid_edge1"}, 64'(out_valid), 64'd1);
    check({tag, "_result"}, 64'(out_result), 64'(exp[IN_W-1:0]));
    check({tag, "_ovf"}, 64'(out_ovf), 64'(exp[IN_W]));
  endtask

  initial begin
    logic [IN_W-1:0] st_s[8];
    logic [IN_W-1:0] st_c[8];
    logic [63:0]     r;
    logic [IN_W:0]   held;
    logic            prev_hold;
    logic            saw_stall;
    logic            acc;
    logic            rdy_seq[7];
    logic            ir_seq[7];
    int              idx;
    int              n0;

    rdy_seq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    ir_seq  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_carry  = '0;
    out_ready = 1'b0;

    // Reset state
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_ovf", 64'(out_ovf), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic resolve, low-to-high carry, overflow through hi carry and top_c
    apply("basic", 40'h00000_00005, 40'h00000_00003);
    check("basic_const", 64'(out_result), 64'h00000_0000B);
    apply("lohi_a", 40'h00000_FFFFF, 40'h0);
    apply("lohi_b", 40'h00000_FFFFF, 40'h1);
    check("lohi_const", 64'(out_result), 64'h00001_00001);
    apply("ovf_hi", 40'hFF_FFFF_FFFF, 40'h1);
    check("ovf_hi_const", 64'({out_ovf, out_result}), 64'h1_00_0000_0001);
    apply("ovf_top", 40'h0, 40'h80_0000_0000);
    check("ovf_top_const", 64'({out_ovf, out_result}), 64'h1_00_0000_0000);

    // Streaming: 8 back-to-back pairs, out_ready low for cycles 3-6
    for (int i = 0; i < 8; i++) begin
      r = {$urandom, $urandom};
      st_s[i] = r[IN_W-1:0];
      r = {$urandom, $urandom};
      st_c[i] = r[IN_W-1:0];
    end
    @(posedge clk); #1;
    n0 = n_out;
    idx = 0;
    prev_hold = 1'b0;
    saw_stall = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 40 && (idx < 8 || sb_q.size() != 0); cyc++) begin
      if (cyc != 0) begin
        @(posedge clk); #1;
      end
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (idx < 8);
      if (idx < 8) begin
        in_sum   = st_s[idx];
        in_carry = st_c[idx];
      end
      @(negedge clk);
      if (prev_hold) begin
        check($sformatf("stall_valid_c%0d", cyc), 64'(out_valid), 64'd1);
        check($sformatf("stall_hold_c%0d", cyc), 64'({out_ovf, out_result}), 64'(held));
      end
      if (in_valid && !in_ready) saw_stall = 1'b1;
      prev_hold = out_valid && !out_ready;
      held = {out_ovf, out_result};
      if (in_valid && in_ready) idx++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("stream_in_ready_fell", 64'(saw_stall), 64'd1);
    check("stream_all_accepted", 64'(idx), 64'd8);
    check("stream_out_count", 64'(n_out - n0), 64'd8);
    check("stream_sb_empty", 64'(sb_q.size()), 64'd0);

    // Simultaneous drain and accept: fill with out_ready low, then 1,0,1,1
    acc = 1'b1;
    for (int cyc = 0; cyc < 7; cyc++) begin
      if (cyc != 0) begin
        @(posedge clk); #1;
      end
      if (acc) begin
        r = {$urandom, $urandom};
        in_sum = r[IN_W-1:0];
        r = {$urandom, $urandom};
        in_carry = r[IN_W-1:0];
      end
      out_ready = rdy_seq[cyc];
      in_valid  = 1'b1;
      @(negedge clk);
      check($sformatf("da_in_ready_c%0d", cyc), 64'(in_ready), 64'(ir_seq[cyc]));
      acc = in_ready;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 10 && sb_q.size() != 0; t++) @(posedge clk);
    #1;
    check("da_sb_empty", 64'(sb_q.size()), 64'd0);

    // Idle holding: out_result keeps the last value after the drain
    held = {out_ovf, out_result};
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("idle_valid", 64'(out_valid), 64'd0);
    check("idle_hold", 64'({out_ovf, out_result}), 64'(held));

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sum    = 40'h12345_6789A;
    in_carry  = 40'h0F0F0_F0F0F;
    @(posedge clk); #1;
    in_sum    = 40'hABCDE_01234;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    @(negedge clk);
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    check("pre_rst_in_ready", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_out_result", 64'(out_result), 64'd0);
    check("async_rst_out_ovf", 64'(out_ovf), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    sb_q.delete();
    @(posedge clk); #1;
    check("in_rst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply("post_rst", 40'h00000_00005, 40'h00000_00003);

    @(posedge clk); #1;
    @(posedge clk); #1;
    check("final_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csa_resolve_pipe.md
Name: csa_resolve_pipe

Overview:
- Final carry-propagate stage downstream of the CSA compression tree in the squaring circuit.
- Takes the redundant sum/carry vector pair from the half/full-adder array and resolves it into one binary result.
- Uses a two-stage pipelined adder (low half, then high half) with valid/ready handshakes on both sides.
- Feeds the squared membrane-potential term to the Izhikevich update datapath.

Parameters:
- IN_W, 40, width of sum and carry vectors and of the result (square of 20-bit operand).
- LO_W, 20, width of the low-half adder in stage 1; the high half is IN_W-LO_W bits; legal range 1..IN_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  sum/carry pair presented
- in_ready  output  1  stage 1 can accept
- in_sum  input  IN_W  sum vector (bitwise XOR outputs of the tree)
- in_carry  input  IN_W  carry vector, unshifted; bit i has weight 2^(i+1)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_result  output  IN_W  (in_sum + (in_carry<<1)) mod 2^IN_W
- out_ovf  output  1  set when the exact sum is >= 2^IN_W

Behaviour:
- One clock, asynchronous active-low reset.
- Reset state: in_ready=1, out_valid=0, out_result=0, out_ovf=0. All stage registers and valid bits clear immediately on rst_n=0, independent of clk.
- Reset mid-operation discards in-flight data. After release, the first accepted input appears 2 cycles after its accept edge.
- Operand formation, combinational at input: A = in_sum; B = {in_carry[IN_W-2:0],1'b0}; top_c = in_carry[IN_W-1].
- Stage 1 register captures:
  - lo_res = A[LO_W-1:0] + B[LO_W-1:0], LO_W bits.
  - c_lo = carry out of that addition.
  - A_hi and B_hi, the upper IN_W-LO_W bits, passed through unadded.
  - top_c.
  - s1_valid.
- Stage 2 register captures:
  - hi_res = A_hi + B_hi + c_lo.
  - out_result = {hi_res, lo_res}.
  - out_ovf = carry out of hi_res OR top_c.
  - s2_valid, which drives out_valid.
- Advance rules:
  - s2_adv = s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || s2_adv.
  - Stage 1 loads when in_valid && in_ready; otherwise s1_valid clears when s2_adv.
  - Stage 2 loads on s2_adv; otherwise out_valid clears when out_ready is high.
- Latency: 2 cycles from the accept edge to out_valid. Throughput: 1 result per cycle when out_ready is held high.
- Backpressure:
  - While out_valid && !out_ready, out_result and out_ovf are held stable.
  - With both stages full and out_ready=0, in_ready=0. No data is dropped or duplicated.
- Simultaneous accept and drain: when stage 1 is full, stage 2 empties (out_ready=1) and in_valid=1 in the same cycle, stage 1 hands off to stage 2 and takes the new input on the same edge.
- in_ready is a pure function of registered state and out_ready; it has no combinational path from in_valid.
- out_* outputs are registered only; there is no combinational path from in_* to out_*.
- Wrap-around: out_result always equals the truncated sum mod 2^IN_W. out_ovf reports the lost bit and never saturates the result.
- Holding rule: when the block is idle, out_result keeps its last value; it is valid only while out_valid=1.

Test Plan:
- Reset, then in_sum=40'h00000_00005, in_carry=40'h00000_00003 with out_ready=1 -> out_valid exactly 2 cycles after accept; out_result=40'h00000_0000B; out_ovf=0.
- Low-to-high carry: in_sum=40'h00000_FFFFF, in_carry=40'h0 followed by in_carry=1 -> out_result=40'h00001_00001, proving c_lo reaches the high half.
- Overflow: in_sum=40'hFF_FFFF_FFFF, in_carry=40'h1 -> out_result=40'h0000000001, out_ovf=1. Then in_sum=0, in_carry=40'h80_0000_0000 -> out_result=0, out_ovf=1 from top_c.
- Streaming with backpressure:
  - Drive 8 back-to-back random pairs; hold out_ready=0 for cycles 3-6.
  - Required: in_ready falls once both stages are full.
  - Required: outputs stay stable while stalled.
  - Required: all 8 results emerge in order and match the reference model, with no loss or duplication.
- Simultaneous drain and accept: with the pipe full and out_ready toggling 1,0,1,1 while in_valid stays high -> an accept occurs on every cycle in which a slot frees; scoreboard matches.
- Asynchronous reset mid-stream: assert rst_n=0 between clock edges with both stages valid -> out_valid=0 and out_result=0 immediately, in_ready=1. The first post-reset input is resolved correctly with latency 2.
